mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read memory port between two requesters.
- Requester I is the instruction fetch path (PC sequencer). Requester D is the data load/store path.
- Uses per-requester valid/ready request and response handshakes, with round-robin arbitration and a one-entry response slot with backpressure.
- Sits between the core front end / LSU and `memory`. It replaces the hard-wired `iaddr`/`daddr` split.

Parameters:
- ADDR_W, 32, byte-address width of requester addresses.
- DATA_W, 32, data word width.
- MEM_WIDTH, 16, word-address width of the memory (memory depth = 2**MEM_WIDTH words).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 at posedge resets).
- i_req_valid  input  1  fetch request valid.
- i_req_ready  output  1  fetch request accepted this cycle.
- i_req_addr  input  ADDR_W  fetch byte address.
- i_rsp_valid  output  1  fetch response valid.
- i_rsp_ready  input  1  fetch response consumed.
- i_rsp_data  output  DATA_W  fetched word.
- i_rsp_err  output  1  misaligned/out-of-range fetch.
- d_req_valid  input  1  data request valid.
- d_req_ready  output  1  data request accepted.
- d_req_we  input  1  1=store, 0=load.
- d_req_addr  input  ADDR_W  data byte address.
- d_req_wdata  input  DATA_W  store data.
- d_rsp_valid  output  1  data response valid (load data or store ack).
- d_rsp_ready  input  1  data response consumed.
- d_rsp_data  output  DATA_W  load data; 0 for stores/errors.
- d_rsp_err  output  1  misaligned/out-of-range access.
- mem_addr  output  MEM_WIDTH  word address to memory.
- mem_we  output  1  memory write enable.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid the cycle after mem_addr is presented.

Behaviour:
- Reset (rst==0 at posedge):
  - Response slot empty; last_gnt=D, so I wins the first tie.
  - All *_ready and *_rsp_valid are 0, mem_we=0, mem_addr=0, rsp_data=0, rsp_err=0.
  - A response pending at reset is dropped and never presented.
- Issue permission: issue_ok = slot empty OR (owner's rsp_valid && owner's rsp_ready) this cycle. At most one request is issued per cycle.
- Arbitration when issue_ok:
  - Only one valid: grant it.
  - Both valid: grant the requester other than last_gnt. last_gnt updates on each issue.
  - x_req_ready = issue_ok && grant==x. It may depend on the other requester's valid, never on its own.
  - Handshake is x_req_valid && x_req_ready. An unaccepted requester must hold valid and payload stable.
- Issue cycle N:
  - mem_addr = addr[MEM_WIDTH+1:2].
  - mem_we = d_req_we for a granted, legal D store; 0 otherwise.
  - mem_wdata = d_req_wdata.
  - Memory writes at the posedge ending cycle N.
  - No issue: mem_we=0, mem_addr=0.
- Illegal access: addr[1:0]!=0 or addr[ADDR_W-1:MEM_WIDTH+2]!=0.
  - The request is still accepted and mem_we is forced to 0.
  - Response has err=1, data=0.
- Response, cycle N+1 (latency exactly 1):
  - Owner's rsp_valid=1.
  - Legal load/fetch: data=mem_rdata, taken directly this cycle.
  - Store: data=0, err=0.
  - The non-owner's rsp_valid is 0.
- Backpressure: if owner rsp_ready==0 at the end of N+1, capture data/err into the hold register.
  - rsp_valid stays 1 with data driven from the hold register until accepted.
  - No issue occurs while the slot is held.
  - Back-to-back throughput is 1 access/cycle when responses are consumed immediately.
- Ordering:
  - A store then a fetch of the same word in the next cycle returns the new value.
  - Alternating I/D traffic interleaves strictly while both are valid.
- rsp_data and rsp_err are 0 whenever the corresponding rsp_valid is 0.

Decomposition:
- Shared package (types.svh):
  - ownerT enum {OWN_I, OWN_D}.
  - memReqT struct {we, addr, wdata}.
  - memRspT struct {data, err}.
  - Alignment/range check function.
- Sub-module mem_rsp_slot holds one response. It has owner, fresh/held flag and hold register, and outputs slot_busy and slot_freeing.
- The arbiter and address mapping stay in mem_port_arbiter.

Test Plan:
- Reset, then rst=1 with I only, addresses 0,4,8, rsp_ready=1 -> i_req_ready=1 every cycle; mem_addr=0,1,2; i_rsp_valid one cycle later each with the preloaded words.
- Both valid every cycle (I fetch 0x10, D load 0x20), responses always ready -> grants alternate I,D,I,D; each rsp_valid only to its owner; first grant to I.
- D store 0x40 data 0xDEADBEEF, next cycle I fetch 0x40 -> mem_we=1 with mem_addr=0x10; d_rsp data=0, err=0; i_rsp_data=0xDEADBEEF.
- I fetch 0x0 with i_rsp_ready=0 for 3 cycles while D is valid -> d_req_ready=0 for 3 cycles; i_rsp_data held stable; D granted in the cycle i_rsp_ready=1.
- D load 0x6 (misaligned) and D load 1<<(MEM_WIDTH+2) -> mem_we=0; d_rsp_err=1, d_rsp_data=0.
- rst=0 asserted while a response is held -> after reset all rsp_valid=0; the held response is never presented; first post-reset tie grants I.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_port_arbiter_pkg;

  // Which requester owns the response slot / won the last grant.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Width the legality check works on; requester addresses are zero-extended to it.
  localparam int unsigned CHK_W = 64;

  // Misaligned word access, or any address bit above the memory word range set.
  function automatic logic addr_illegal(input logic [CHK_W-1:0] addr,
                                        input int unsigned      mem_w);
    logic bad;
    bad = (addr[1:0] != 2'b00);
    if ((addr >> (mem_w + 2)) != '0) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rsp_slot.sv
// One-entry response slot: remembers who owns the in-flight access and holds its response.
// Latency: response presented the cycle after issue, data taken straight from mem_rdata.
// Backpressure: if the owner does not consume, data/err are captured and replayed until taken.
module mem_port_arbiter_rsp_slot
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  owner_e            issue_owner,
  input  logic              issue_zero,
  input  logic              issue_err,
  input  logic              i_rsp_ready,
  input  logic              d_rsp_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              i_rsp_valid,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              slot_busy,
  output logic              slot_freeing
);

  owner_e            owner_q, owner_d;
  logic              vld_q, vld_d;
  logic              held_q, held_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] cur_data;
  logic              out_vld;
  logic              owner_rdy;

  // Present the response: fresh memory data on the first cycle, the hold register afterwards.
  always_comb begin
    out_vld      = rst && vld_q;
    cur_data     = held_q ? hold_q : (zero_q ? '0 : mem_rdata);
    owner_rdy    = (owner_q == OWN_I) ? i_rsp_ready : d_rsp_ready;
    slot_busy    = vld_q;
    slot_freeing = out_vld && owner_rdy;
    i_rsp_valid  = out_vld && (owner_q == OWN_I);
    d_rsp_valid  = out_vld && (owner_q == OWN_D);
    rsp_data     = out_vld ? cur_data : '0;
    rsp_err      = out_vld && err_q;
  end

  // Slot next state: a new issue replaces a consumed entry, an unconsumed fresh one is captured.
  always_comb begin
    owner_d = owner_q;
    vld_d   = vld_q;
    held_d  = held_q;
    zero_d  = zero_q;
    err_d   = err_q;
    hold_d  = hold_q;
    if (issue) begin
      owner_d = issue_owner;
      vld_d   = 1'b1;
      held_d  = 1'b0;
      zero_d  = issue_zero;
      err_d   = issue_err;
    end else if (slot_freeing) begin
      vld_d  = 1'b0;
      held_d = 1'b0;
    end else if (vld_q && !held_q) begin
      held_d = 1'b1;
      hold_d = cur_data;
    end
  end

  // Slot registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_I;
      vld_q   <= 1'b0;
      held_q  <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      vld_q   <= vld_d;
      held_q  <= held_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one synchronous-read memory port between fetch (I) and data (D).
// Latency: request issued in cycle N, response valid to its owner in N+1 (1 access/cycle peak).
// Backpressure: an unconsumed response is held and blocks further issue until its owner takes it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [ADDR_W-1:0]    i_req_addr,
  output logic                 i_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_W-1:0]    i_rsp_data,
  output logic                 i_rsp_err,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_we,
  input  logic [ADDR_W-1:0]    d_req_addr,
  input  logic [DATA_W-1:0]    d_req_wdata,
  output logic                 d_rsp_valid,
  input  logic                 d_rsp_ready,
  output logic [DATA_W-1:0]    d_rsp_data,
  output logic                 d_rsp_err,
  output logic [MEM_WIDTH-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  owner_e            last_gnt_q, last_gnt_d;
  owner_e            gnt_owner;
  mem_req_t          req;
  logic [CHK_W-1:0]  req_addr_ext;
  logic              req_bad;
  logic              issue_ok;
  logic              gnt_i, gnt_d;
  logic              issue;
  logic              slot_busy, slot_freeing;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Grant selection and address mapping; a requester's ready never looks at its own valid.
  always_comb begin
    issue_ok     = rst && (!slot_busy || slot_freeing);
    gnt_i        = !d_req_valid || (last_gnt_q == OWN_D);
    gnt_d        = !i_req_valid || (last_gnt_q == OWN_I);
    i_req_ready  = issue_ok && gnt_i;
    d_req_ready  = issue_ok && gnt_d;
    issue        = (i_req_valid && i_req_ready) || (d_req_valid && d_req_ready);
    gnt_owner    = (i_req_valid && i_req_ready) ? OWN_I : OWN_D;
    req.we       = (gnt_owner == OWN_D) && d_req_we;
    req.addr     = (gnt_owner == OWN_I) ? i_req_addr : d_req_addr;
    req.wdata    = d_req_wdata;
    req_addr_ext = '0;
    req_addr_ext[ADDR_W-1:0] = req.addr;
    req_bad      = addr_illegal(req_addr_ext, MEM_WIDTH);
    mem_addr     = issue ? req.addr[MEM_WIDTH+1:2] : '0;
    mem_we       = issue && req.we && !req_bad;
    mem_wdata    = req.wdata;
    last_gnt_d   = issue ? gnt_owner : last_gnt_q;
  end

  // Round-robin pointer; after reset D counts as last so I wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt_q <= OWN_D;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  mem_port_arbiter_rsp_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk          (clk),
    .rst          (rst),
    .issue        (issue),
    .issue_owner  (gnt_owner),
    .issue_zero   (req.we || req_bad),
    .issue_err    (req_bad),
    .i_rsp_ready  (i_rsp_ready),
    .d_rsp_ready  (d_rsp_ready),
    .mem_rdata    (mem_rdata),
    .i_rsp_valid  (i_rsp_valid),
    .d_rsp_valid  (d_rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .slot_busy    (slot_busy),
    .slot_freeing (slot_freeing)
  );

  // Route the shared response to its owner only; the other side sees zeros.
  always_comb begin
    i_rsp_data = i_rsp_valid ? rsp_data : '0;
    i_rsp_err  = i_rsp_valid && rsp_err;
    d_rsp_data = d_rsp_valid ? rsp_data : '0;
    d_rsp_err  = d_rsp_valid && rsp_err;
  end

endmodule
